// File: rtl/frm_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module : frm_tx_pkg
// Brief  : Shared definitions for the downlink frame transmit scheduler.
//          Frame type codes, scheduler state encoding, parameter defaults
//          and the fixed-priority request picker.
// Rev    : 1.0  initial release
// ============================================================================
package frm_tx_pkg;

  // Frame type codes driven on tx_type (2'd3 is reserved, never driven)
  localparam logic [1:0] TYPE_STAR  = 2'd0;
  localparam logic [1:0] TYPE_TELE  = 2'd1;
  localparam logic [1:0] TYPE_LIGHT = 2'd2;

  localparam int unsigned NUM_SRC = 3;

  localparam logic [15:0] GAP_CYC_DEF     = 16'd100;
  localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd10000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  // Pending vector is indexed by type code. Telemetry wins, then star,
  // then light. Only meaningful when at least one bit is set.
  function automatic logic [1:0] prio_pick(input logic [2:0] pend);
    if (pend[TYPE_TELE]) begin
      return TYPE_TELE;
    end else if (pend[TYPE_STAR]) begin
      return TYPE_STAR;
    end else begin
      return TYPE_LIGHT;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/frm_req_latch.sv
`default_nettype none
// ============================================================================
// Module : frm_req_latch
// Brief  : Pending-request flag for one frame source, with overflow strobe.
// Ports  : clk, rst_n      clock / async active-low reset
//          en             transmit enable; low clears and refuses requests
//          req            1-clk request pulse
//          grant          1-clk grant from the scheduler (clears the flag)
//          pend           pending flag
//          ovf            1-clk strobe: request lost to an already-set flag
// Rev    : 1.0  initial release
// ============================================================================
module frm_req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req,
  input  logic grant,
  output logic pend,
  output logic ovf
);

  // A request arriving with its own grant re-arms the flag; that is a new
  // request, not a lost one, so it does not count as overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (!en) begin
      pend <= 1'b0;
    end else if (req) begin
      pend <= 1'b1;
    end else if (grant) begin
      pend <= 1'b0;
    end
  end

  assign ovf = en & req & pend & ~grant;

endmodule
`default_nettype wire

// File: rtl/frm_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : frm_tx_scheduler
// Brief  : Shares the downlink frame transmitter among the star-image diag,
//          telemetry and light/spot diag triggers. Latches requests, grants
//          one frame at a time by fixed priority (TELE > STAR > LIGHT),
//          waits for tx_done, then holds an inter-frame gap.
// Config : FRM_TX_TIMEOUT_EN  enables the BUSY watchdog and timeout_flag.
// Ports  : clk, rst_n        clock / async active-low reset
//          frm_tx_en         transmit enable
//          req_star/tele/light  1-clk frame requests
//          tx_done           1-clk frame-finished pulse from transmitter
//          err_clr           clears timeout_flag
//          tx_start          1-clk start pulse to transmitter
//          tx_type           frame type, held from tx_start to next grant
//          transmit_done     1-clk normal completion pulse
//          sched_busy        high in START/BUSY/GAP
//          ovf_cnt           saturating count of lost requests
//          timeout_flag      sticky watchdog flag
// Rev    : 1.0  initial release
// ============================================================================
module frm_tx_scheduler
  import frm_tx_pkg::*;
#(
  parameter logic [15:0] GAP_CYC     = GAP_CYC_DEF,
  parameter logic [31:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF  // must be >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frm_tx_en,
  input  logic        req_star,
  input  logic        req_tele,
  input  logic        req_light,
  input  logic        tx_done,
  input  logic        err_clr,
  output logic        tx_start,
  output logic [1:0]  tx_type,
  output logic        transmit_done,
  output logic        sched_busy,
  output logic [15:0] ovf_cnt,
  output logic        timeout_flag
);

  sched_state_t state, state_nxt;
  logic [2:0]   req_vec, pend, grant, ovf_strb;
  logic [1:0]   win_type;
  logic [15:0]  gap_cnt;
  logic         gap_done;
  logic         tmo_hit;
  logic [1:0]   ovf_sum;
  logic [16:0]  ovf_next;

  // Bit position equals the frame type code
  assign req_vec = {req_light, req_tele, req_star};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    frm_req_latch u_latch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (frm_tx_en),
      .req   (req_vec[i]),
      .grant (grant[i]),
      .pend  (pend[i]),
      .ovf   (ovf_strb[i])
    );
  end

  assign win_type = prio_pick(pend);

  // GAP lasts GAP_CYC clocks, but never less than one
  assign gap_done = (GAP_CYC == 16'd0) || (gap_cnt >= GAP_CYC - 16'd1);

  always_comb begin
    state_nxt = state;
    grant     = 3'b000;
    case (state)
      ST_IDLE: begin
        if (frm_tx_en && (|pend)) begin
          state_nxt = ST_START;
          grant     = 3'b001 << win_type;
        end
      end
      ST_START: state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (tx_done || tmo_hit) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ovf_sum  = {1'b0, ovf_strb[0]} + {1'b0, ovf_strb[1]} + {1'b0, ovf_strb[2]};
  assign ovf_next = {1'b0, ovf_cnt} + {15'd0, ovf_sum};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      tx_type       <= TYPE_STAR;
      transmit_done <= 1'b0;
      gap_cnt       <= 16'd0;
      ovf_cnt       <= 16'd0;
    end else begin
      state         <= state_nxt;
      // A watchdog expiry leaves BUSY without tx_done, so it never reports here
      transmit_done <= (state == ST_BUSY) && tx_done;
      if ((state == ST_IDLE) && (state_nxt == ST_START)) begin
        tx_type <= win_type;
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
      ovf_cnt <= ovf_next[16] ? 16'hFFFF : ovf_next[15:0];
    end
  end

  assign tx_start   = (state == ST_START);
  assign sched_busy = (state != ST_IDLE);

`ifdef FRM_TX_TIMEOUT_EN
  logic [31:0] busy_cnt;

  // busy_cnt is 0 on the first BUSY clock, so expiry falls on clock TIMEOUT_CYC
  assign tmo_hit = (state == ST_BUSY) && !tx_done && (busy_cnt >= TIMEOUT_CYC - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt     <= 32'd0;
      timeout_flag <= 1'b0;
    end else begin
      busy_cnt <= (state == ST_BUSY) ? busy_cnt + 32'd1 : 32'd0;
      // A new timeout outranks a simultaneous clear
      if (tmo_hit) begin
        timeout_flag <= 1'b1;
      end else if (err_clr) begin
        timeout_flag <= 1'b0;
      end
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
  assign unused_tmo   = ^{err_clr, TIMEOUT_CYC};
`endif

endmodule
`default_nettype wire

// File: tb/tb_frm_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_frm_tx_scheduler
// Brief  : Scoreboard bench for frm_tx_scheduler. A timestamp-based reference
//          model predicts each tx_start (cycle, type) and transmit_done cycle
//          into queues; a monitor pops and compares as the DUT presents them.
// Rev    : 1.0  initial release
// ============================================================================
module tb_frm_tx_scheduler;

  localparam logic [15:0] GAP     = 16'd12;
  localparam int          GAP_EFF = (GAP == 16'd0) ? 1 : int'(GAP);
  localparam int          TMO     = 1000;
`ifdef FRM_TX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, frm_tx_en, req_star, req_tele, req_light, tx_done, err_clr;
  logic        tx_start, transmit_done, sched_busy, timeout_flag;
  logic [1:0]  tx_type;
  logic [15:0] ovf_cnt;

  frm_tx_scheduler #(.GAP_CYC(GAP), .TIMEOUT_CYC(32'(TMO))) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frm_tx_en     (frm_tx_en),
    .req_star      (req_star),
    .req_tele      (req_tele),
    .req_light     (req_light),
    .tx_done       (tx_done),
    .err_clr       (err_clr),
    .tx_start      (tx_start),
    .tx_type       (tx_type),
    .transmit_done (transmit_done),
    .sched_busy    (sched_busy),
    .ovf_cnt       (ovf_cnt),
    .timeout_flag  (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int t; int c; } exp_t;
  exp_t startq[$];
  int   doneq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_light = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (evaluated on each rising edge) -------
  bit [2:0] m_pend;
  bit       m_inflight, m_tmo, m_sbusy, m_gnt, m_hit;
  int       m_busy_edge, m_next_ok, m_ovf, m_type, m_gt;
  bit [2:0] rq;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      m_pend = 3'b000; m_inflight = 0; m_tmo = 0; m_sbusy = 0;
      m_busy_edge = 0; m_next_ok = 0; m_ovf = 0; m_type = 0;
      startq.delete(); doneq.delete();
    end else begin
      m_gnt = 0; m_hit = 0; m_gt = 0;
      rq = {req_light, req_tele, req_star};
      if (m_inflight && cyc >= m_busy_edge) begin
        if (tx_done) begin
          m_inflight = 0;
          doneq.push_back(cyc);
          m_next_ok = cyc + GAP_EFF + 1;
        end else if (TMO_EN && cyc == m_busy_edge + TMO - 1) begin
          m_inflight = 0;
          m_hit = 1;
          m_next_ok = cyc + GAP_EFF + 1;
        end
      end else if (!m_inflight && cyc >= m_next_ok && frm_tx_en && m_pend != 3'b000) begin
        m_gt = m_pend[1] ? 1 : (m_pend[0] ? 0 : 2);
        m_gnt = 1;
        m_inflight = 1;
        m_busy_edge = cyc + 2;
        m_type = m_gt;
        startq.push_back('{t: m_gt, c: cyc});
      end
      for (int x = 0; x < 3; x++) begin
        if (!frm_tx_en) begin
          m_pend[x] = 1'b0;
        end else if (rq[x]) begin
          if (m_pend[x] && !(m_gnt && m_gt == x) && m_ovf < 65535) m_ovf++;
          m_pend[x] = 1'b1;
        end else if (m_gnt && m_gt == x) begin
          m_pend[x] = 1'b0;
        end
      end
      if (m_hit) m_tmo = 1;
      else if (err_clr) m_tmo = 0;
      m_sbusy = m_inflight || (cyc < m_next_ok - 1);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (tx_start) begin
      if (startq.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_start: got unexpected start type=%0d expected none (cyc %0d)", tx_type, cyc);
      end else begin
        e = startq.pop_front();
        chk("start_cyc", cyc, e.c);
        chk("start_type", int'(tx_type), e.t);
        if (tx_type == 2'd2) n_light++;
      end
    end else if (startq.size() != 0 && startq[0].c <= cyc) begin
      e = startq.pop_front();
      total++; bad++;
      $display("FAIL tx_start: got none expected start type=%0d at cyc %0d", e.t, e.c);
    end
    if (transmit_done) begin
      if (doneq.size() == 0) begin
        total++; bad++;
        $display("FAIL transmit_done: got unexpected pulse expected none (cyc %0d)", cyc);
      end else begin
        d = doneq.pop_front();
        chk("done_cyc", cyc, d);
      end
    end else if (doneq.size() != 0 && doneq[0] <= cyc) begin
      d = doneq.pop_front();
      total++; bad++;
      $display("FAIL transmit_done: got none expected pulse at cyc %0d", d);
    end
    chk("sched_busy", int'(sched_busy), int'(m_sbusy));
    chk("ovf_cnt", int'(ovf_cnt), m_ovf);
    chk("timeout_flag", int'(timeout_flag), int'(m_tmo));
    chk("tx_type_hold", int'(tx_type), m_type);
  end

  // ---------------- transmitter responder (sole driver of tx_done) -------
  bit auto_resp = 1;
  bit spurious  = 0;
  int resp_fixed = 0;
  int resp_cnt = 0;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) tx_done = 1'b1;
    end
    if (spurious && $urandom_range(0, 99) == 0) tx_done = 1'b1;
    if (tx_start && auto_resp)
      resp_cnt = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(1, 30));
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit s, input bit t, input bit l);
    @(negedge clk);
    req_star = s; req_tele = t; req_light = l;
    @(negedge clk);
    req_star = 0; req_tele = 0; req_light = 0;
  endtask

  task automatic wait_busy(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sched_busy) return;
    end
    total++; bad++;
    $display("FAIL wait_busy: got idle expected busy within %0d cycles", lim);
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (!sched_busy && resp_cnt == 0 && m_pend == 3'b000) return;
    end
    total++; bad++;
    $display("FAIL wait_idle: got busy expected idle within %0d cycles", lim);
  endtask

  initial begin
    int ovf_base, light_base;
    rst_n = 0; frm_tx_en = 0; req_star = 0; req_tele = 0; req_light = 0; err_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_type", int'(tx_type), 0);
    chk("rst_transmit_done", int'(transmit_done), 0);
    chk("rst_sched_busy", int'(sched_busy), 0);
    chk("rst_ovf_cnt", int'(ovf_cnt), 0);
    chk("rst_timeout_flag", int'(timeout_flag), 0);
    @(negedge clk); #2 rst_n = 1;
    frm_tx_en = 1;

    // single telemetry frame, transmitter answers after 50 clocks
    resp_fixed = 50;
    pulse(0, 1, 0);
    wait_idle(300);

    // simultaneous requests
    resp_fixed = 0;
    pulse(1, 1, 1);
    wait_idle(600);

    // extra star requests while a star frame is in flight
    resp_fixed = 60;
    ovf_base = int'(ovf_cnt);
    pulse(1, 0, 0);
    wait_busy(10);
    pulse(1, 0, 0);
    repeat (3) @(negedge clk);
    pulse(1, 0, 0);
    wait_idle(600);
    chk("ovf_delta", int'(ovf_cnt) - ovf_base, 1);

    // enable dropped during BUSY with a light request pending
    resp_fixed = 40;
    light_base = n_light;
    pulse(0, 1, 0);
    wait_busy(10);
    pulse(0, 0, 1);
    @(negedge clk); frm_tx_en = 0;
    repeat (3) @(negedge clk); frm_tx_en = 1;
    wait_idle(300);
    chk("no_light_frame", n_light - light_base, 0);

`ifdef FRM_TX_TIMEOUT_EN
    // watchdog: no tx_done at all
    auto_resp = 0;
    pulse(1, 0, 0);
    repeat (TMO + 10) @(negedge clk);
    chk("timeout_set", int'(timeout_flag), 1);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("timeout_cleared", int'(timeout_flag), 0);
    auto_resp = 1;
    wait_idle(300);
`endif

    // reset in BUSY with pending requests; late tx_done must be ignored
    resp_fixed = 60;
    pulse(0, 1, 1);
    wait_busy(10);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    chk("midrst_tx_start", int'(tx_start), 0);
    chk("midrst_sched_busy", int'(sched_busy), 0);
    chk("midrst_tx_type", int'(tx_type), 0);
    #2 rst_n = 1;
    repeat (80) @(negedge clk);
    chk("post_rst_idle", int'(sched_busy), 0);

    // randomized traffic
    resp_fixed = 0;
    spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req_star  = ($urandom_range(0, 19) == 0);
      req_tele  = ($urandom_range(0, 19) == 0);
      req_light = ($urandom_range(0, 19) == 0);
      err_clr   = ($urandom_range(0, 49) == 0);
      if (frm_tx_en) frm_tx_en = ($urandom_range(0, 59) != 0);
      else           frm_tx_en = ($urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    req_star = 0; req_tele = 0; req_light = 0; err_clr = 0;
    spurious = 0; frm_tx_en = 1;
    wait_idle(2000);
    repeat (5) @(negedge clk);
    chk("startq_drained", startq.size(), 0);
    chk("doneq_drained", doneq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
